// File: rtl/seq_multiplier32_pkg.sv
// Shared definitions for the sequential multiplier and later multi-cycle ALU stages.
// State encodings and the fixed iteration count of the 32-bit datapath.
package seq_multiplier32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MULT_ITERATIONS = 32;

endpackage

// File: rtl/seq_multiplier32_adder.sv
// 32-bit ripple-carry adder used for each partial-sum addition.
// Purely combinational; the unsigned datapath has no use for an overflow flag.
module FullAdder32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carryin,
    output logic [31:0] sum,
    output logic        carryout
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = carryin;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        carryout = carry;
    end

endmodule

// File: rtl/seq_multiplier32.sv
// Unsigned 32x32->64 shift-and-add multiplier, one multiplier bit per iteration.
// Each iteration gives the ripple adder SETTLE_CYCLES clocks before capture.
module seq_multiplier32
    import seq_multiplier32_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   mcand;
    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [31:0]   addend;
    logic [31:0]   sum;
    logic          carryout;
    logic [4:0]    iter;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          capture;
    logic          last;

    assign addend = lo[0] ? mcand : '0;

    FullAdder32bit u_adder (
        .a        (hi),
        .b        (addend),
        .carryin  (1'b0),
        .sum      (sum),
        .carryout (carryout)
    );

    // Operands are latched on the accepting edge so a/b need only be valid then.
    assign accept  = start && (state == IDLE || state == DONE);
    assign capture = (state == RUN) && (cnt == '0);
    assign last    = capture && (iter == 5'(MULT_ITERATIONS - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: state_nxt = start ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            iter  <= '0;
            cnt   <= '0;
        end else if (accept) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
        end else if (state == LOAD) begin
            iter <= '0;
            cnt  <= CNT_INIT;
        end else if (state == RUN) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else begin
                {hi, lo} <= {carryout, sum, lo[31:1]};
                iter     <= iter + 5'd1;
                cnt      <= CNT_INIT;
            end
        end
    end

    assign busy    = (state == LOAD) || (state == RUN);
    assign done    = (state == DONE);
    assign product = {hi, lo};

endmodule

// File: tb/tb_seq_multiplier32.sv
// Self-checking bench for seq_multiplier32 (SETTLE_CYCLES=1 and 3).
// Expected products come from plain 64-bit multiplication.
module tb_seq_multiplier32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start1 = 1'b0;
    logic [31:0] a1 = '0;
    logic [31:0] b1 = '0;
    logic        busy1;
    logic        done1;
    logic [63:0] product1;
    logic        start3 = 1'b0;
    logic [31:0] a3 = '0;
    logic [31:0] b3 = '0;
    logic        busy3;
    logic        done3;
    logic [63:0] product3;

    int checks = 0;
    int errors = 0;

    always #500 clk = ~clk;

    seq_multiplier32 #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start1),
        .a       (a1),
        .b       (b1),
        .busy    (busy1),
        .done    (done1),
        .product (product1)
    );

    seq_multiplier32 #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start3),
        .a       (a3),
        .b       (b3),
        .busy    (busy3),
        .done    (done3),
        .product (product3)
    );

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic busy_of(input bit sel);
        return sel ? busy3 : busy1;
    endfunction

    function automatic logic done_of(input bit sel);
        return sel ? done3 : done1;
    endfunction

    function automatic logic [63:0] prod_of(input bit sel);
        return sel ? product3 : product1;
    endfunction

    task automatic set_in(input bit sel, input logic s, input logic [31:0] x, input logic [31:0] y);
        if (sel) begin
            start3 = s; a3 = x; b3 = y;
        end else begin
            start1 = s; a1 = x; b1 = y;
        end
    endtask

    // Present operands for one cycle; returns at the negedge of the first busy cycle.
    task automatic start_op(input bit sel, input logic [31:0] x, input logic [31:0] y);
        set_in(sel, 1'b1, x, y);
        @(negedge clk);
        set_in(sel, 1'b0, $urandom, $urandom);
    endtask

    // Counts busy cycles from the current negedge; returns at the DONE negedge.
    task automatic wait_done(input string tag, input bit sel, input logic [63:0] exp, input int n_exp);
        int n = 0;
        while (busy_of(sel) && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 64'(n), 64'(n_exp));
        chk({tag, "_done"}, 64'(done_of(sel)), 64'd1);
        chk({tag, "_prod"}, prod_of(sel), exp);
    endtask

    task automatic check_pulse(input string tag, input bit sel, input logic [63:0] exp);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(done_of(sel)), 64'd0);
        chk({tag, "_hold"}, prod_of(sel), exp);
    endtask

    task automatic full_op(input string tag, input bit sel, input logic [31:0] x, input logic [31:0] y);
        int s = sel ? 3 : 1;
        start_op(sel, x, y);
        wait_done(tag, sel, model(x, y), 1 + 32 * s);
        check_pulse(tag, sel, model(x, y));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        #1;
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_prod", product1, 64'd0);
        chk("rst_prod3", product3, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        full_op("t1", 1'b0, 32'd9, 32'd15);
        full_op("t2", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        full_op("t3a", 1'b0, 32'd0, 32'h12345678);
        full_op("t3b", 1'b0, 32'h12345678, 32'd0);

        start_op(1'b0, 32'd5, 32'd9);
        wait_done("t4a", 1'b0, 64'd45, 33);
        set_in(1'b0, 1'b1, 32'd3, 32'd7);
        @(negedge clk);
        set_in(1'b0, 1'b0, 32'd0, 32'd0);
        chk("t4_nogap", 64'(busy1), 64'd1);
        wait_done("t4b", 1'b0, 64'd21, 33);
        check_pulse("t4b", 1'b0, 64'd21);

        start_op(1'b0, 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        set_in(1'b0, 1'b1, 32'd1, 32'd1);
        @(negedge clk);
        set_in(1'b0, 1'b0, 32'd0, 32'd0);
        wait_done("t5", 1'b0, 64'd42, 27);
        check_pulse("t5", 1'b0, 64'd42);

        start_op(1'b0, 32'hDEADBEEF, 32'hCAFEF00D);
        repeat (11) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6_busy", 64'(busy1), 64'd0);
        chk("t6_done", 64'(done1), 64'd0);
        chk("t6_prod", product1, 64'd0);
        repeat (2) @(negedge clk);
        chk("t6_nodone", 64'(done1), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_idle", 64'(busy1), 64'd0);
        full_op("t6", 1'b0, 32'd2, 32'd5);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            full_op("rnd", 1'b0, ra, rb);
        end

        full_op("s3_t1", 1'b1, 32'd9, 32'd15);
        full_op("s3_t2", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        ra = $urandom;
        rb = $urandom;
        full_op("s3_rnd", 1'b1, ra, rb);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
